// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encoding, slice width and op codes.
package alu_pkg;

    localparam int unsigned SLICE = 4;

    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

endpackage : alu_pkg

// File: rtl/cla_slice4.sv
// Purely combinational 4-bit carry-look-ahead adder slice.
module cla_slice4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    assign p = a ^ b;
    assign g = a & b;

    // Look-ahead carries into each bit, all derived directly from P/G and cin
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s = p ^ c;

endmodule : cla_slice4

// File: rtl/addsub32_slice_sequencer.sv
// Multi-cycle add/subtract unit: one nibble per cycle through a shared CLA slice.
module addsub32_slice_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf,
    output logic             o_zero
);

    localparam int unsigned NSLICE = WIDTH / SLICE;
    localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

    seq_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic             ready_q;
    logic             valid_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    logic [SLICE-1:0] sl_s;
    logic             sl_cout;
    logic [WIDTH-1:0] res_d;

    // The single shared slice always works on the low nibble of the operand shifters
    cla_slice4 u_slice (
        .a    (a_q[SLICE-1:0]),
        .b    (b_q[SLICE-1:0]),
        .cin  (carry_q),
        .s    (sl_s),
        .cout (sl_cout)
    );

    // Result fills from the top so the first nibble ends up at the bottom after NSLICE shifts
    assign res_d = {sl_s, res_q[WIDTH-1:SLICE]};

    // Sequencer FSM with nibble count, carry flop, shift registers and result flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (i_valid && ready_q) begin
                        a_q     <= i_a;
                        b_q     <= (i_sub == ALU_OP_ADD) ? i_b : ~i_b;
                        carry_q <= (i_sub == ALU_OP_SUB);
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> SLICE;
                    b_q     <= b_q >> SLICE;
                    res_q   <= res_d;
                    carry_q <= sl_cout;
                    if (cnt_q == LAST_CNT) begin
                        // Carry into the MSB is a^b^s at bit 3 of the last slice
                        cout_q  <= sl_cout;
                        ovf_q   <= a_q[SLICE-1] ^ b_q[SLICE-1] ^ sl_s[SLICE-1] ^ sl_cout;
                        zero_q  <= (res_d == '0);
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    ready_q <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_sum   = res_q;
    assign o_cout  = cout_q;
    assign o_ovf   = ovf_q;
    assign o_zero  = zero_q;

endmodule : addsub32_slice_sequencer

// File: tb/tb_addsub32_slice_sequencer.sv
// Randomized self-checking bench for addsub32_slice_sequencer against an arithmetic model.
module tb_addsub32_slice_sequencer;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned LATENCY = 8;

    logic             clk;
    logic             rst_n;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_sub;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_sum;
    logic             o_cout;
    logic             o_ovf;
    logic             o_zero;

    int errors;
    int checks;

    addsub32_slice_sequencer #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_sub   (i_sub),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_sum   (o_sum),
        .o_cout  (o_cout),
        .o_ovf   (o_ovf),
        .o_zero  (o_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: plain 33-bit arithmetic and sign rules for overflow
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         output logic [31:0] sum, output logic cout,
                         output logic ovf, output logic zero);
        logic [32:0] full;
        if (sub) full = {1'b0, a} - {1'b0, b};
        else     full = {1'b0, a} + {1'b0, b};
        sum  = full[31:0];
        // For subtraction carry-out means "no borrow", i.e. a >= b unsigned
        cout = sub ? (a >= b) : full[32];
        if (sub) ovf = (a[31] != b[31]) && (sum[31] != a[31]);
        else     ovf = (a[31] == b[31]) && (sum[31] != a[31]);
        zero = (sum == 32'd0);
    endtask

    // Wait (bounded) for the unit to be ready, sampled on the falling edge
    task automatic wait_ready(output bit ok);
        int n;
        n  = 0;
        ok = 1'b1;
        while (o_ready !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (o_ready !== 1'b1) begin
            ok = 1'b0;
            check("ready_timeout", {31'd0, o_ready}, 32'd1);
        end
    endtask

    // One full transaction; hold > 0 keeps i_ready low that many cycles in DONE
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input int hold, input string tag);
        logic [31:0] e_sum;
        logic        e_cout, e_ovf, e_zero;
        int          lat;
        bit          ok;
        model(a, b, sub, e_sum, e_cout, e_ovf, e_zero);
        i_ready = (hold == 0);
        wait_ready(ok);
        if (!ok) return;
        i_valid = 1'b1;
        i_a     = a;
        i_b     = b;
        i_sub   = sub;
        @(negedge clk);
        // Operands change after accept and must not matter
        i_valid = 1'b0;
        i_a     = $urandom;
        i_b     = $urandom;
        i_sub   = ~sub;
        check({tag, "_run_ready"}, {31'd0, o_ready}, 32'd0);
        lat = 0;
        while (o_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, LATENCY);
        check({tag, "_sum"}, o_sum, e_sum);
        check({tag, "_cout"}, {31'd0, o_cout}, {31'd0, e_cout});
        check({tag, "_ovf"}, {31'd0, o_ovf}, {31'd0, e_ovf});
        check({tag, "_zero"}, {31'd0, o_zero}, {31'd0, e_zero});
        for (int h = 0; h < hold; h++) begin
            // Offer a competing request while the result is stalled
            i_valid = 1'b1;
            i_a     = $urandom;
            i_b     = $urandom;
            @(negedge clk);
            check({tag, "_bp_valid"}, {31'd0, o_valid}, 32'd1);
            check({tag, "_bp_ready"}, {31'd0, o_ready}, 32'd0);
            check({tag, "_bp_sum"}, o_sum, e_sum);
            check({tag, "_bp_flags"}, {29'd0, o_cout, o_ovf, o_zero},
                  {29'd0, e_cout, e_ovf, e_zero});
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(negedge clk);
        check({tag, "_released"}, {31'd0, o_valid}, 32'd0);
        check({tag, "_idle_ready"}, {31'd0, o_ready}, 32'd1);
    endtask

    initial begin
        bit ok;
        bit seen;
        errors  = 0;
        checks  = 0;
        clk     = 1'b0;
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_a     = '0;
        i_b     = '0;
        i_sub   = 1'b0;
        i_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_outputs", {26'd0, o_ready, o_valid, o_cout, o_ovf, o_zero, 1'b0}, 32'd0);
        check("rst_sum", o_sum, 32'd0);
        rst_n = 1'b1;

        // Directed boundary cases
        do_op(32'h0000_0000, 32'h0000_0000, 1'b0, 0, "add_zero");
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, "add_ripple");
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, "add_ovf");
        do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 0, "sub_ovf");
        do_op(32'h0000_0005, 32'h0000_0007, 1'b1, 0, "sub_borrow");
        do_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 5, "backpressure");

        // Reset in the middle of an operation
        i_ready = 1'b1;
        wait_ready(ok);
        if (ok) begin
            i_valid = 1'b1;
            i_a     = 32'hCAFE_F00D;
            i_b     = 32'h0101_0101;
            i_sub   = 1'b0;
            @(negedge clk);
            i_valid = 1'b0;
            repeat (3) @(negedge clk);
            rst_n = 1'b0;
            #1;
            check("midrst_outputs", {26'd0, o_ready, o_valid, o_cout, o_ovf, o_zero, 1'b0}, 32'd0);
            check("midrst_sum", o_sum, 32'd0);
            @(negedge clk);
            rst_n = 1'b1;
            seen  = 1'b0;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                if (o_valid === 1'b1) seen = 1'b1;
            end
            check("midrst_no_result", {31'd0, seen}, 32'd0);
        end
        do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 0, "after_rst");

        // Randomized operands, op and result backpressure
        for (int t = 0; t < 24; t++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            if (t % 6 == 0) rb = ra;
            do_op(ra, rb, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_addsub32_slice_sequencer
